// File: rtl/wam_mole_if.sv
// Board-side bundle between the mole spawner and the game front end:
// run and hit go into the spawner; the board state and outcome pulses come back out.
interface wam_mole_if;
  logic       run;
  logic [7:0] hit;
  logic [7:0] holes;
  logic [7:0] whack;
  logic [7:0] escape;
  logic [3:0] up_cnt;

  modport master (output run, output hit,
                  input holes, input whack, input escape, input up_cnt);
  modport slave  (input run, input hit,
                  output holes, output whack, output escape, output up_cnt);
endinterface

// File: rtl/wam_mole.sv
// Mole spawner and lifetime manager: raises moles at LFSR-chosen holes and
// retires each one on a hit or on lifetime expiry, pulsing whack or escape.
module wam_mole #(
  parameter int          SPAWN_GAP = 8,
  parameter int          LIFE      = 24,
  parameter int          MAX_UP    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk_19,
  input  logic        rst_n,
  wam_mole_if.slave   bus
);

  localparam int GAP_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam int LIFE_W = (LIFE > 1) ? $clog2(LIFE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LIFE_W-1:0] life_q [8];
  logic [LIFE_W-1:0] life_d [8];
  logic [15:0]       lfsr_q, lfsr_d;
  logic [7:0]        holes_q, holes_d;
  logic [7:0]        whack_q, whack_d;
  logic [7:0]        escape_q, escape_d;
  logic [3:0]        up_cnt_q, up_cnt_d;
  logic [2:0]        idx;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + 4'(v[i]);
    return sum;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    holes_d  = holes_q;
    whack_d  = '0;
    escape_d = '0;
    idx      = lfsr_q[2:0];
    for (int i = 0; i < 8; i++) life_d[i] = life_q[i];

    case (state_q)
      IDLE: begin
        holes_d = '0;
        for (int i = 0; i < 8; i++) life_d[i] = '0;
        if (bus.run) begin
          state_d = RUN;
          gap_d   = GAP_W'(SPAWN_GAP - 1);
        end
      end
      RUN: begin
        if (!bus.run) begin
          // Dropping run wipes the board silently; the LFSR keeps its place.
          state_d = IDLE;
          holes_d = '0;
          gap_d   = '0;
          for (int i = 0; i < 8; i++) life_d[i] = '0;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          for (int i = 0; i < 8; i++) begin
            if (holes_q[i]) begin
              if (bus.hit[i]) begin
                holes_d[i] = 1'b0;
                whack_d[i] = 1'b1;
              end else if (life_q[i] == '0) begin
                holes_d[i]  = 1'b0;
                escape_d[i] = 1'b1;
              end else begin
                life_d[i] = life_q[i] - 1'b1;
              end
            end
          end
          // Spawn looks at pre-edge occupancy, so a hole vacating this edge is still busy.
          if (gap_q == '0) begin
            gap_d = GAP_W'(SPAWN_GAP - 1);
            if (!holes_q[idx] && (up_cnt_q < 4'(MAX_UP))) begin
              holes_d[idx] = 1'b1;
              life_d[idx]  = LIFE_W'(LIFE - 1);
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    up_cnt_d = popcount8(holes_d);
  end

  always_ff @(posedge clk_19 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      holes_q  <= '0;
      whack_q  <= '0;
      escape_q <= '0;
      up_cnt_q <= '0;
      for (int i = 0; i < 8; i++) life_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      lfsr_q   <= lfsr_d;
      holes_q  <= holes_d;
      whack_q  <= whack_d;
      escape_q <= escape_d;
      up_cnt_q <= up_cnt_d;
      for (int i = 0; i < 8; i++) life_q[i] <= life_d[i];
    end
  end

  assign bus.holes  = holes_q;
  assign bus.whack  = whack_q;
  assign bus.escape = escape_q;
  assign bus.up_cnt = up_cnt_q;

endmodule
